// File: rtl/keypad_pin_ctrl.sv
// keypad_pin_ctrl
// Sits behind the 3x4 keypad row scanner. It debounces the scanner's
// per-cycle code stream into single-shot key events and collects a
// fixed-length PIN. It checks the PIN against pin_ref and drives the
// unlock / fail / lockout status.
//
// Optional feature macro: KEYPAD_PIN_LOCKOUT_EN
//   defined   -> MAX_FAIL consecutive failures put the FSM in LOCK for LOCK_CYC cycles
//   undefined -> LOCK unreachable, locked tied low
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   key_inp    in   scanner code: 0-9 digits, 10 '*', 11 '#', 12-15 none
//   pin_ref    in   reference PIN, first digit in the most-significant nibble
//   key_valid  out  one-cycle pulse per accepted key
//   key_code   out  code of the last accepted key (12 after reset)
//   digit_cnt  out  digits entered so far
//   unlock     out  high while in OPEN
//   fail       out  one-cycle pulse on a wrong or short PIN
//   locked     out  high while in LOCK
//   state      out  IDLE=0 ENTRY=1 CHECK=2 OPEN=3 FAIL=4 LOCK=5
module keypad_pin_ctrl #(
   parameter int DIGITS   = 4,
   parameter int DEB_CNT  = 8,
   parameter int GAP_CYC  = 8,
   parameter int OPEN_CYC = 1000,
   parameter int MAX_FAIL = 3,
   parameter int LOCK_CYC = 5000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          key_inp,
   input  logic [4*DIGITS-1:0] pin_ref,
   output logic                key_valid,
   output logic [3:0]          key_code,
   output logic [3:0]          digit_cnt,
   output logic                unlock,
   output logic                fail,
   output logic                locked,
   output logic [2:0]          state
);

   localparam int BUF_W   = 4 * DIGITS;
   localparam int SIGHT_W = $clog2(DEB_CNT + 1);
   localparam int GAP_W   = $clog2(GAP_CYC + 1);
   localparam int TMR_MAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

   localparam logic [3:0] CODE_STAR = 4'd10;
   localparam logic [3:0] CODE_HASH = 4'd11;
   localparam logic [3:0] CODE_NONE = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTRY = 3'd1,
      S_CHECK = 3'd2,
      S_OPEN  = 3'd3,
      S_FAIL  = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   // debouncer
   logic [3:0]         cand_q, cand_d;
   logic [SIGHT_W-1:0] sight_q, sight_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               pressed_q, pressed_d;
   logic               key_valid_q, key_valid_d;
   logic [3:0]         key_code_q, key_code_d;

   // PIN FSM
   state_t             state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [3:0]         digit_cnt_q, digit_cnt_d;
   logic               ovf_q, ovf_d;
   logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               unlock_q, unlock_d;
   logic               fail_q, fail_d;
   logic               is_digit;
   logic               is_end_key;

   // ---------------------------------------------------------------
   // Debouncer: the scanner only shows a held key every 4th cycle, so
   // short gaps keep the press alive; GAP_CYC empty cycles release it.
   // ---------------------------------------------------------------
   always_comb begin
      cand_d      = cand_q;
      sight_d     = sight_q;
      gap_d       = gap_q;
      pressed_d   = pressed_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;

      if (key_inp <= CODE_HASH) begin
         gap_d = '0;
         if (key_inp == cand_q) begin
            if (sight_q != SIGHT_W'(DEB_CNT)) begin
               sight_d = sight_q + 1'b1;
            end
         end else begin
            // a new code restarts the count but leaves pressed alone, so
            // rolling onto a second key never yields a second event
            cand_d  = key_inp;
            sight_d = SIGHT_W'(1);
         end
      end else begin
         if (gap_q != GAP_W'(GAP_CYC)) begin
            gap_d = gap_q + 1'b1;
         end
         if (gap_d == GAP_W'(GAP_CYC)) begin
            pressed_d = 1'b0;
            sight_d   = '0;
            cand_d    = CODE_NONE;
         end
      end

      if ((sight_d == SIGHT_W'(DEB_CNT)) && !pressed_q) begin
         pressed_d   = 1'b1;
         key_valid_d = 1'b1;
         key_code_d  = cand_d;
      end
   end

   // ---------------------------------------------------------------
   // PIN FSM: acts on the registered key event (key_valid_q/key_code_q)
   // ---------------------------------------------------------------
   assign is_digit   = (key_code_q <= 4'd9);
   assign is_end_key = (key_code_q == CODE_STAR) || (key_code_q == CODE_HASH);

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      digit_cnt_d = digit_cnt_q;
      ovf_d       = ovf_q;
      fail_cnt_d  = fail_cnt_q;
      timer_d     = timer_q;

      case (state_q)
         S_IDLE: begin
            if (key_valid_q && is_digit) begin
               buf_d       = BUF_W'({buf_q, key_code_q});
               digit_cnt_d = 4'd1;
               state_d     = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (key_valid_q) begin
               if (is_digit) begin
                  if (digit_cnt_q < 4'(DIGITS)) begin
                     buf_d       = BUF_W'({buf_q, key_code_q});
                     digit_cnt_d = digit_cnt_q + 4'd1;
                  end else begin
                     // too many digits: remember it so CHECK rejects the entry
                     ovf_d = 1'b1;
                  end
               end else if (key_code_q == CODE_STAR) begin
                  digit_cnt_d = 4'd0;
                  ovf_d       = 1'b0;
                  state_d     = S_IDLE;
               end else if (key_code_q == CODE_HASH) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            digit_cnt_d = 4'd0;
            ovf_d       = 1'b0;
            if ((digit_cnt_q == 4'(DIGITS)) && !ovf_q && (buf_q == pin_ref)) begin
               state_d    = S_OPEN;
               fail_cnt_d = '0;
               timer_d    = '0;
            end else begin
               state_d = S_FAIL;
               if (fail_cnt_q != FAIL_W'(MAX_FAIL)) begin
                  fail_cnt_d = fail_cnt_q + 1'b1;
               end
            end
         end
         S_OPEN: begin
            if ((key_valid_q && is_end_key) || (timer_q == TMR_W'(OPEN_CYC - 1))) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_FAIL: begin
`ifdef KEYPAD_PIN_LOCKOUT_EN
            if (fail_cnt_q == FAIL_W'(MAX_FAIL)) begin
               state_d = S_LOCK;
               timer_d = '0;
            end else begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
`ifdef KEYPAD_PIN_LOCKOUT_EN
         S_LOCK: begin
            if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
               state_d    = S_IDLE;
               fail_cnt_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // status outputs are registered copies of the next state
      unlock_d = (state_d == S_OPEN);
      fail_d   = (state_d == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q      <= CODE_NONE;
         sight_q     <= '0;
         gap_q       <= '0;
         pressed_q   <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= CODE_NONE;
         state_q     <= S_IDLE;
         buf_q       <= '0;
         digit_cnt_q <= 4'd0;
         ovf_q       <= 1'b0;
         fail_cnt_q  <= '0;
         timer_q     <= '0;
         unlock_q    <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         cand_q      <= cand_d;
         sight_q     <= sight_d;
         gap_q       <= gap_d;
         pressed_q   <= pressed_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         state_q     <= state_d;
         buf_q       <= buf_d;
         digit_cnt_q <= digit_cnt_d;
         ovf_q       <= ovf_d;
         fail_cnt_q  <= fail_cnt_d;
         timer_q     <= timer_d;
         unlock_q    <= unlock_d;
         fail_q      <= fail_d;
      end
   end

`ifdef KEYPAD_PIN_LOCKOUT_EN
   logic locked_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= (state_d == S_LOCK);
      end
   end
   assign locked = locked_q;
`else
   assign locked = 1'b0;
`endif

   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign digit_cnt = digit_cnt_q;
   assign unlock    = unlock_q;
   assign fail      = fail_q;
   assign state     = state_q;

endmodule

// File: tb/tb_keypad_pin_ctrl.sv
// tb_keypad_pin_ctrl
// Scoreboard bench for keypad_pin_ctrl. Stimulus pushes the expected
// output events (key events, digit_cnt/state changes, unlock/fail/locked
// edges with latency or width, reset snapshots) into a queue. The monitor
// pops one entry for every event the DUT presents.
module tb_keypad_pin_ctrl;

   localparam int OPEN_CYC = 1000;
   localparam int LOCK_CYC = 5000;
`ifdef KEYPAD_PIN_LOCKOUT_EN
   localparam bit LOCK_BUILD = 1'b1;
`else
   localparam bit LOCK_BUILD = 1'b0;
`endif

   localparam int EV_KEY    = 0;
   localparam int EV_CNT    = 1;
   localparam int EV_ST     = 2;
   localparam int EV_UNL_R  = 3;
   localparam int EV_UNL_F  = 4;
   localparam int EV_FAIL_R = 5;
   localparam int EV_FAIL_F = 6;
   localparam int EV_LCK_R  = 7;
   localparam int EV_LCK_F  = 8;
   localparam int EV_RST    = 9;
   // reset snapshot {key_valid,key_code,digit_cnt,unlock,fail,locked,state}
   localparam int RST_SNAP  = 12 << 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_inp = 4'd12;
   logic [15:0] pin_ref = 16'h1234;
   logic        key_valid, unlock, fail, locked;
   logic [3:0]  key_code, digit_cnt;
   logic [2:0]  state;

   keypad_pin_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .key_inp   (key_inp),
      .pin_ref   (pin_ref),
      .key_valid (key_valid),
      .key_code  (key_code),
      .digit_cnt (digit_cnt),
      .unlock    (unlock),
      .fail      (fail),
      .locked    (locked),
      .state     (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   ev_t   exp_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    done = 1'b0;
   string knames[10] = '{"key", "digit_cnt", "state", "unlock_rise", "unlock_width",
                         "fail_rise", "fail_width", "locked_rise", "locked_width", "reset"};

   function automatic void push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   int         cyc = 0;
   int         last_kv = 0, unl_t = 0, fail_t = 0, lck_t = 0;
   logic [3:0] p_cnt;
   logic [2:0] p_st;
   logic       p_unl, p_fail, p_lck;
   bit         rst_chk = 1'b0;

   task automatic observe(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got val=%0d, required no event (cycle %0d)",
                  knames[kind], val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            errors++;
            $display("FAIL %s: got %s=%0d, required %s=%0d (cycle %0d)",
                     knames[e.kind], knames[kind], val, knames[e.kind], e.val, cyc);
         end else begin
            $display("ok   %s val=%0d (cycle %0d)", knames[kind], val, cyc);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         if (!rst_chk) begin
            observe(EV_RST, int'({key_valid, key_code, digit_cnt, unlock, fail, locked, state}));
            rst_chk = 1'b1;
         end
      end else begin
         rst_chk = 1'b0;
         if (key_valid) begin
            observe(EV_KEY, int'(key_code));
            last_kv = cyc;
         end
         if (digit_cnt != p_cnt) observe(EV_CNT, int'(digit_cnt));
         if (state != p_st) observe(EV_ST, int'(state));
         if (unlock && !p_unl) begin
            observe(EV_UNL_R, cyc - last_kv);
            unl_t = cyc;
         end
         if (!unlock && p_unl) observe(EV_UNL_F, cyc - unl_t);
         if (fail && !p_fail) begin
            observe(EV_FAIL_R, cyc - last_kv);
            fail_t = cyc;
         end
         if (!fail && p_fail) observe(EV_FAIL_F, cyc - fail_t);
         if (locked && !p_lck) begin
            observe(EV_LCK_R, cyc - last_kv);
            lck_t = cyc;
         end
         if (!locked && p_lck) observe(EV_LCK_F, cyc - lck_t);
      end
      p_cnt  = digit_cnt;
      p_st   = state;
      p_unl  = unlock;
      p_fail = fail;
      p_lck  = locked;

      if (done || cyc > 40000) begin
         checks++;
         if (!done) begin
            errors++;
            $display("FAIL timeout: cycle %0d reached, stimulus still running", cyc);
         end else if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d still expected (next %s=%0d), required 0",
                     exp_q.size(), knames[exp_q[0].kind], exp_q[0].val);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   // held key: the code appears on every 4th cycle, none otherwise
   task automatic hold(input logic [3:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         key_inp = (i % 4 == 0) ? code : 4'd12;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         key_inp = 4'd12;
      end
   endtask

   task automatic press(input logic [3:0] code);
      hold(code, 40);
      idle(20);
   endtask

   // one key press with its expected digit_cnt / state change (-1 = none)
   task automatic key_ev(input logic [3:0] code, input int cnt, input int st);
      push(EV_KEY, int'(code));
      if (cnt >= 0) push(EV_CNT, cnt);
      if (st >= 0) push(EV_ST, st);
      press(code);
   endtask

   task automatic enter_1234();
      key_ev(4'd1, 1, 1);
      key_ev(4'd2, 2, -1);
      key_ev(4'd3, 3, -1);
      key_ev(4'd4, 4, -1);
   endtask

   task automatic hash_ok();
      push(EV_KEY, 11);
      push(EV_ST, 2);
      push(EV_CNT, 0);
      push(EV_ST, 3);
      push(EV_UNL_R, 2);
      push(EV_ST, 0);
      push(EV_UNL_F, OPEN_CYC);
      press(4'd11);
      idle(OPEN_CYC + 50);
   endtask

   task automatic hash_bad(input bit to_lock);
      push(EV_KEY, 11);
      push(EV_ST, 2);
      push(EV_CNT, 0);
      push(EV_ST, 4);
      push(EV_FAIL_R, 2);
      push(EV_ST, to_lock ? 5 : 0);
      push(EV_FAIL_F, 1);
      if (to_lock) push(EV_LCK_R, 3);
      press(4'd11);
   endtask

   initial begin
      push(EV_RST, RST_SNAP);
      idle(4);
      rst = 1'b0;

      // long hold of '1' gives a single event; '*' returns to IDLE
      push(EV_KEY, 1);
      push(EV_CNT, 1);
      push(EV_ST, 1);
      hold(4'd1, 200);
      idle(20);
      key_ev(4'd10, 0, 0);

      // correct PIN
      enter_1234();
      hash_ok();

      // wrong, short and overflowing PINs
      key_ev(4'd1, 1, 1);
      key_ev(4'd2, 2, -1);
      key_ev(4'd3, 3, -1);
      key_ev(4'd5, 4, -1);
      hash_bad(1'b0);
      key_ev(4'd1, 1, 1);
      key_ev(4'd2, 2, -1);
      hash_bad(1'b0);
      enter_1234();
      key_ev(4'd5, -1, -1);
      hash_bad(LOCK_BUILD);

`ifdef KEYPAD_PIN_LOCKOUT_EN
      // keys during lockout produce events but no FSM effect
      key_ev(4'd1, -1, -1);
      key_ev(4'd2, -1, -1);
      key_ev(4'd3, -1, -1);
      key_ev(4'd4, -1, -1);
      key_ev(4'd11, -1, -1);
      push(EV_ST, 0);
      push(EV_LCK_F, LOCK_CYC);
      idle(LOCK_CYC);
      enter_1234();
      hash_ok();
`endif

      // '*' abandons an entry
      key_ev(4'd9, 1, 1);
      key_ev(4'd9, 2, -1);
      key_ev(4'd10, 0, 0);
      enter_1234();
      hash_ok();

      // reset mid-entry with '2' held across it
      key_ev(4'd1, 1, 1);
      push(EV_KEY, 2);
      push(EV_CNT, 2);
      hold(4'd2, 40);
      push(EV_RST, RST_SNAP);
      rst = 1'b1;
      hold(4'd2, 4);
      rst = 1'b0;
      push(EV_KEY, 2);
      push(EV_CNT, 1);
      push(EV_ST, 1);
      hold(4'd2, 40);
      idle(20);
      key_ev(4'd10, 0, 0);
      enter_1234();
      hash_ok();

      done = 1'b1;
   end

endmodule
